// File: rtl/debug_cmd_rx_if.sv
// debug_cmd_rx_if: UART/gb_clk inputs and halt/command outputs of the debug command receiver.
interface debug_cmd_rx_if;
  logic       rx;
  logic       gb_clk;
  logic       halt;
  logic       stepping;
  logic       cmd_valid;
  logic [7:0] cmd_byte;
  logic       frame_err;
  logic       tx;
  modport master (output rx, gb_clk, input halt, stepping, cmd_valid, cmd_byte, frame_err, tx);
  modport slave (input rx, gb_clk, output halt, stepping, cmd_valid, cmd_byte, frame_err, tx);
endinterface

// File: rtl/debug_cmd_rx.sv
// debug_cmd_rx: UART command receiver driving a glitch-free core halt level with N-cycle stepping.
// Define CMD_ECHO_EN to build the 8N1 echo transmitter on tx; otherwise tx is tied high.
module debug_cmd_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int SYNC_STAGES  = 2
) (
  input logic           clk,
  input logic           rst_n,
  debug_cmd_rx_if.slave bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [1:0] RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3;
  localparam logic [1:0] DEC_CMD = 2'd0, DEC_ARG = 2'd1, DEC_STEP = 2'd2;
  logic [SYNC_STAGES-1:0] rx_sync_q, gb_sync_q;
  logic                   gb_prev_q, rx_s, gb_rise;
  logic [1:0]             rx_st_q, rx_st_d, dec_q, dec_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             idx_q, idx_d;
  logic [7:0]             shift_q, shift_d, step_q, step_d, byte_q, byte_d;
  logic                   wait_hi_q, wait_hi_d, byte_rdy, ferr;
  logic                   halt_q, halt_d, stepping_q, stepping_d, valid_q, valid_d;
  logic                   ferr_q, done_q, done_d;
  logic                   is_h, is_r, is_t, is_s;
  assign rx_s    = rx_sync_q[SYNC_STAGES-1];
  assign gb_rise = gb_sync_q[SYNC_STAGES-1] & ~gb_prev_q;
  assign is_h    = shift_q == 8'h48;
  assign is_r    = shift_q == 8'h52;
  assign is_t    = shift_q == 8'h54;
  assign is_s    = shift_q == 8'h53;
  always_comb begin
    rx_st_d   = rx_st_q;
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    shift_d   = shift_q;
    wait_hi_d = wait_hi_q & ~rx_s;
    byte_rdy  = 1'b0;
    ferr      = 1'b0;
    case (rx_st_q)
      RX_IDLE: begin
        cnt_d   = '0;
        rx_st_d = (!rx_s && !wait_hi_q) ? RX_START : RX_IDLE;
      end
      RX_START: if (cnt_q == HALF) begin
        cnt_d   = '0;
        idx_d   = '0;
        ferr    = rx_s;
        rx_st_d = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt_q == LAST) begin
        cnt_d          = '0;
        shift_d[idx_q] = rx_s;
        idx_d          = idx_q + 1'b1;
        rx_st_d        = (idx_q == 3'd7) ? RX_STOP : RX_DATA;
      end
      default: if (cnt_q == LAST) begin
        // A low stop bit means the line may still be low: wait for idle before re-arming.
        cnt_d     = '0;
        rx_st_d   = RX_IDLE;
        byte_rdy  = rx_s;
        ferr      = ~rx_s;
        wait_hi_d = ~rx_s;
      end
    endcase
  end
  always_comb begin
    dec_d      = dec_q;
    step_d     = step_q;
    halt_d     = halt_q;
    stepping_d = stepping_q;
    valid_d    = 1'b0;
    byte_d     = byte_q;
    done_d     = 1'b0;
    case (dec_q)
      DEC_CMD: if (byte_rdy && (is_h || is_r || is_t || is_s)) begin
        valid_d = 1'b1;
        byte_d  = shift_q;
        halt_d  = is_h ? 1'b1 : is_t ? ~halt_q : is_s ? halt_q : 1'b0;
        dec_d   = is_s ? DEC_ARG : DEC_CMD;
      end
      DEC_ARG: if (ferr) dec_d = DEC_CMD;
      else if (byte_rdy) begin
        step_d     = shift_q;
        halt_d     = (shift_q != 8'd0) ? 1'b0 : halt_q;
        stepping_d = shift_q != 8'd0;
        dec_d      = (shift_q != 8'd0) ? DEC_STEP : DEC_CMD;
      end
      default: if (byte_rdy && (is_h || is_r)) begin
        // Abort bytes take priority over a coincident gb_rise.
        valid_d    = 1'b1;
        byte_d     = shift_q;
        halt_d     = is_h;
        stepping_d = 1'b0;
        dec_d      = DEC_CMD;
      end else if (gb_rise) begin
        step_d = step_q - 1'b1;
        if (step_q == 8'd1) begin
          halt_d     = 1'b1;
          stepping_d = 1'b0;
          done_d     = 1'b1;
          dec_d      = DEC_CMD;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync_q  <= '1;
      gb_sync_q  <= '0;
      gb_prev_q  <= 1'b0;
      rx_st_q    <= RX_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      wait_hi_q  <= 1'b0;
      dec_q      <= DEC_CMD;
      step_q     <= '0;
      halt_q     <= 1'b0;
      stepping_q <= 1'b0;
      valid_q    <= 1'b0;
      byte_q     <= '0;
      ferr_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rx_sync_q  <= {rx_sync_q[SYNC_STAGES-2:0], bus.rx};
      gb_sync_q  <= {gb_sync_q[SYNC_STAGES-2:0], bus.gb_clk};
      gb_prev_q  <= gb_sync_q[SYNC_STAGES-1];
      rx_st_q    <= rx_st_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      wait_hi_q  <= wait_hi_d;
      dec_q      <= dec_d;
      step_q     <= step_d;
      halt_q     <= halt_d;
      stepping_q <= stepping_d;
      valid_q    <= valid_d;
      byte_q     <= byte_d;
      ferr_q     <= ferr;
      done_q     <= done_d;
    end
  end
  assign bus.halt      = halt_q;
  assign bus.stepping  = stepping_q;
  assign bus.cmd_valid = valid_q;
  assign bus.cmd_byte  = byte_q;
  assign bus.frame_err = ferr_q;
`ifdef CMD_ECHO_EN
  logic          tx_busy_q;
  logic [9:0]    tx_frame_q;
  logic [CW-1:0] tx_cnt_q;
  logic [3:0]    tx_bits_q;
  // Frame is {stop, data, start} shifted out LSB first; shifting in ones leaves the line idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy_q  <= 1'b0;
      tx_frame_q <= '1;
      tx_cnt_q   <= '0;
      tx_bits_q  <= '0;
    end else if (!tx_busy_q) begin
      if (valid_q || done_q) begin
        tx_busy_q  <= 1'b1;
        tx_frame_q <= {1'b1, done_q ? 8'h2E : byte_q, 1'b0};
        tx_cnt_q   <= '0;
        tx_bits_q  <= '0;
      end
    end else if (tx_cnt_q == LAST) begin
      tx_cnt_q   <= '0;
      tx_frame_q <= {1'b1, tx_frame_q[9:1]};
      tx_bits_q  <= tx_bits_q + 1'b1;
      tx_busy_q  <= tx_bits_q != 4'd9;
    end else tx_cnt_q <= tx_cnt_q + 1'b1;
  end
  assign bus.tx = tx_frame_q[0];
`else
  logic unused_done;
  assign unused_done = done_q;
  assign bus.tx      = 1'b1;
`endif
endmodule

// File: tb/tb_debug_cmd_rx.sv
// tb_debug_cmd_rx: directed UART command vectors with hand-computed halt/step/echo expectations.
module tb_debug_cmd_rx;
  localparam int CPB = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  int   checks = 0, errors = 0;
  int   cyc = 0, vcnt = 0, vcyc = 0, fcnt = 0, scnt = 0, txfall = 0, txlow = 0;
  logic [7:0] vbyte = 8'h00, eb;
  logic       vhalt = 1'b0, tx_prev = 1'b1, eok;
  int   v0, f0, s0, n;
  logic sok;
  debug_cmd_rx_if dbg();
  debug_cmd_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(dbg));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    tx_prev <= dbg.tx;
    if (dbg.cmd_valid) begin
      vcnt  <= vcnt + 1;
      vbyte <= dbg.cmd_byte;
      vhalt <= dbg.halt;
      vcyc  <= cyc;
    end
    if (dbg.frame_err) fcnt <= fcnt + 1;
    if (dbg.stepping) scnt <= scnt + 1;
    if (!dbg.tx && tx_prev) txfall <= cyc;
    if (!dbg.tx) txlow <= txlow + 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send_frame(input logic [7:0] b, input logic stop);
    dbg.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      dbg.rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    dbg.rx = stop;
    repeat (CPB) @(negedge clk);
    dbg.rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask
  task automatic gb_pulses(input int k);
    for (int i = 0; i < k; i++) begin
      dbg.gb_clk = 1'b1;
      repeat (6) @(negedge clk);
      dbg.gb_clk = 1'b0;
      repeat (6) @(negedge clk);
    end
  endtask
`ifdef CMD_ECHO_EN
  task automatic get_tx(output logic [7:0] b, output logic ok);
    int w;
    w  = 0;
    b  = 8'h00;
    ok = 1'b0;
    while (dbg.tx && w < 40 * CPB) begin
      @(negedge clk);
      w++;
    end
    if (!dbg.tx) begin
      repeat (CPB / 2) @(negedge clk);
      ok = !dbg.tx;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = dbg.tx;
      end
      repeat (CPB) @(negedge clk);
      ok = ok & dbg.tx;
    end
  endtask
`endif
  initial begin
    dbg.rx = 1'b1;
    dbg.gb_clk = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_halt", dbg.halt, 0);
    check("rst_stepping", dbg.stepping, 0);
    check("rst_cmd_valid", dbg.cmd_valid, 0);
    check("rst_cmd_byte", dbg.cmd_byte, 8'h00);
    check("rst_frame_err", dbg.frame_err, 0);
    check("rst_tx", dbg.tx, 1);
    // reset in the middle of an 'H' frame
    v0 = vcnt;
    dbg.rx = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    rst_n = 1'b0;
    dbg.rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (CPB * 10) @(negedge clk);
    check("midrst_halt", dbg.halt, 0);
    check("midrst_valid", vcnt - v0, 0);
    send_frame(8'h48, 1'b1);
    check("H_halt", dbg.halt, 1);
    check("H_valid", vcnt - v0, 1);
    check("H_byte", vbyte, 8'h48);
    send_frame(8'h52, 1'b1);
    check("R_halt", dbg.halt, 0);
    v0 = vcnt;
    send_frame(8'h54, 1'b1);
    check("T1_halt", dbg.halt, 1);
    send_frame(8'h54, 1'b1);
    check("T2_halt", dbg.halt, 0);
    send_frame(8'h41, 1'b1);
    check("A_halt", dbg.halt, 0);
    check("TTA_valid", vcnt - v0, 2);
    check("TTA_byte", vbyte, 8'h54);
    // five-cycle step from halted
    send_frame(8'h48, 1'b1);
    send_frame(8'h53, 1'b1);
    check("S_arg_halt", dbg.halt, 1);
    check("S_arg_stepping", dbg.stepping, 0);
    check("S_byte", vbyte, 8'h53);
    v0 = vcnt;
    send_frame(8'h05, 1'b1);
    check("N5_halt", dbg.halt, 0);
    check("N5_stepping", dbg.stepping, 1);
    check("N5_no_valid", vcnt - v0, 0);
    n = 0;
    sok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      dbg.gb_clk = 1'b1;
      if (dbg.halt) break;
      n++;
      if (!dbg.stepping) sok = 1'b0;
      repeat (6) @(negedge clk);
      dbg.gb_clk = 1'b0;
      repeat (6) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    dbg.gb_clk = 1'b0;
    repeat (6) @(negedge clk);
    check("N5_edges", n, 5);
    check("N5_stepping_held", sok, 1);
    check("N5_end_halt", dbg.halt, 1);
    check("N5_end_stepping", dbg.stepping, 0);
    // zero-length step is a no-op
    s0 = scnt;
    send_frame(8'h53, 1'b1);
    send_frame(8'h00, 1'b1);
    check("N0_halt", dbg.halt, 1);
    check("N0_stepping_cycles", scnt - s0, 0);
    // long step aborted by 'H'
    send_frame(8'h53, 1'b1);
    send_frame(8'hFF, 1'b1);
    gb_pulses(10);
    check("NFF_halt", dbg.halt, 0);
    check("NFF_stepping", dbg.stepping, 1);
    v0 = vcnt;
    send_frame(8'h54, 1'b1);
    check("NFF_T_ignored", vcnt - v0, 0);
    check("NFF_T_halt", dbg.halt, 0);
    send_frame(8'h48, 1'b1);
    check("abort_valid", vcnt - v0, 1);
    check("abort_halt_at_valid", vhalt, 1);
    check("abort_stepping", dbg.stepping, 0);
    check("abort_byte", vbyte, 8'h48);
    // bad stop bit on 'R' is discarded
    v0 = vcnt;
    f0 = fcnt;
    send_frame(8'h52, 1'b0);
    check("stop0_ferr", fcnt - f0, 1);
    check("stop0_valid", vcnt - v0, 0);
    check("stop0_halt", dbg.halt, 1);
    // frame error while waiting for the step argument cancels the step
    send_frame(8'h53, 1'b1);
    send_frame(8'h05, 1'b0);
    send_frame(8'h05, 1'b1);
    check("argerr_stepping", dbg.stepping, 0);
    check("argerr_halt", dbg.halt, 1);
    check("argerr_ferr", fcnt - f0, 2);
    // short low glitch on idle line
    v0 = vcnt;
    f0 = fcnt;
    dbg.rx = 1'b0;
    repeat (5) @(negedge clk);
    dbg.rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("glitch_ferr", fcnt - f0, 1);
    check("glitch_valid", vcnt - v0, 0);
`ifdef CMD_ECHO_EN
    repeat (12 * CPB) @(negedge clk);
    fork
      send_frame(8'h52, 1'b1);
      get_tx(eb, eok);
    join
    check("echo_R_byte", eb, 8'h52);
    check("echo_R_frame", eok, 1);
    check("echo_R_latency", txfall - vcyc, 1);
    repeat (12 * CPB) @(negedge clk);
    fork
      begin
        send_frame(8'h53, 1'b1);
        send_frame(8'h01, 1'b1);
      end
      get_tx(eb, eok);
    join
    check("echo_S_byte", eb, 8'h53);
    check("echo_S_frame", eok, 1);
    check("N1_stepping", dbg.stepping, 1);
    fork
      gb_pulses(1);
      get_tx(eb, eok);
    join
    check("echo_dot_byte", eb, 8'h2E);
    check("echo_dot_frame", eok, 1);
    check("N1_halt", dbg.halt, 1);
`else
    check("tx_never_low", txlow, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
